mem_wb_skid_reg: RTL and testbench

- Parametrised MEM->WB pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer. It replaces the plain always-load stage register.
- Adds backpressure, flush and a registered-path writeback value mux.
- Upstream is the memory stage. Downstream is writeback / register-file write port and the forwarding unit.

---
 rtl/mem_wb_skid_reg.sv | 133 +++++++++++++
 tb/tb_mem_wb_skid_reg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline boundary register with a valid/ready handshake and a
// 2-entry skid buffer (head H drives the outputs, skid S catches the entry
// that arrives while the head is stalled).
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, outputs show a bubble
//   ST_ONE   | head holds an entry, skid free (in_ready=1)
//   ST_FULL  | head and skid both hold entries (in_ready=0)
//
// The state encoding is {H_valid, S_valid}. The combination (0,1) is never
// produced and is steered back to ST_EMPTY if it ever appears.
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read_in,
  input  logic              wb_en_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_result_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_read,
  output logic              wb_en,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] wb_value,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              mem_read;
    logic              wb_en;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  entry_t h_q, h_d;
  entry_t s_q, s_d;
  entry_t in_entry;

  logic h_valid;
  logic s_valid;
  logic accept;
  logic pop;

  assign in_entry = '{mem_read: mem_read_in, wb_en: wb_en_in, dest: dest_in,
                      alu: alu_result_in, mem: mem_result_in};

  assign h_valid = state_q[1];
  assign s_valid = state_q[0];

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = h_valid & out_ready;

  // State and payload registers; reset clears payload so no X reaches outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      h_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end

  // Next state and payload loads; flush empties the buffer but leaves payload stale.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          h_d     = in_entry;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          h_d = in_entry;
        end else if (accept) begin
          state_d = ST_FULL;
          s_d     = in_entry;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          h_d     = s_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Outputs come from the head register only; wb_en is masked on bubbles.
  always_comb begin
    out_valid  = h_valid;
    mem_read   = h_q.mem_read;
    wb_en      = h_q.wb_en & h_valid;
    dest       = h_q.dest;
    alu_result = h_q.alu;
    mem_result = h_q.mem;
    wb_value   = h_q.mem_read ? h_q.mem : h_q.alu;
    occupancy  = 2'(h_valid) + 2'(s_valid);
  end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: directed vector table, then random traffic
// checked against a FIFO-queue model of the buffer.
module tb_mem_wb_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        mem_read_in, wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_result_in, mem_result_in;
  logic        out_valid, out_ready, mem_read, wb_en;
  logic [3:0]  dest;
  logic [31:0] alu_result, mem_result, wb_value;
  logic [1:0]  occupancy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_wb_skid_reg #(.DATA_W(32), .DEST_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_read_in(mem_read_in), .wb_en_in(wb_en_in), .dest_in(dest_in),
    .alu_result_in(alu_result_in), .mem_result_in(mem_result_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_read(mem_read), .wb_en(wb_en), .dest(dest),
    .alu_result(alu_result), .mem_result(mem_result),
    .wb_value(wb_value), .occupancy(occupancy)
  );

  typedef struct {
    logic        rst, flush, iv, ordy, mr, we;
    logic [3:0]  dst;
    logic [31:0] alu, mem;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [3:0]  e_dst;
    logic [31:0] e_wbv;
    logic        e_wbe, chk_pay;
  } vec_t;

  typedef struct {
    logic        mr, we;
    logic [3:0]  dst;
    logic [31:0] alu, mem;
  } ent_t;

  vec_t vq[$];
  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic add(input logic r, f, iv, ordy, mr, we, input logic [3:0] dst,
                     input logic [31:0] alu, mem, input logic ov, ir,
                     input logic [1:0] occ, input logic [3:0] edst,
                     input logic [31:0] wbv, input logic wbe, cp);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.mr = mr; v.we = we;
    v.dst = dst; v.alu = alu; v.mem = mem;
    v.e_ov = ov; v.e_ir = ir; v.e_occ = occ; v.e_dst = edst;
    v.e_wbv = wbv; v.e_wbe = wbe; v.chk_pay = cp;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, f, iv, ordy, mr, we, input logic [3:0] dst,
                       input logic [31:0] alu, mem);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    mem_read_in = mr; wb_en_in = we; dest_in = dst;
    alu_result_in = alu; mem_result_in = mem;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

    //   rst fl iv or mr we dst   alu            mem            ov ir occ edst  wbv            wbe cp
    // reset held two cycles with an entry offered
    add(1, 0, 1, 0, 0, 1, 4'hA, 32'h0000_00AA, 32'h0000_0055, 0, 1, 0, 4'h0, 32'h0, 0, 1);
    add(1, 0, 1, 0, 0, 1, 4'hA, 32'h0000_00AA, 32'h0000_0055, 0, 1, 0, 4'h0, 32'h0, 0, 1);
    // streaming
    add(0, 0, 1, 1, 0, 1, 4'h1, 32'h10, 32'h1, 1, 1, 1, 4'h1, 32'h10, 1, 1);
    add(0, 0, 1, 1, 0, 1, 4'h2, 32'h20, 32'h2, 1, 1, 1, 4'h2, 32'h20, 1, 1);
    add(0, 0, 1, 1, 0, 1, 4'h3, 32'h30, 32'h3, 1, 1, 1, 4'h3, 32'h30, 1, 1);
    add(0, 0, 1, 1, 0, 1, 4'h4, 32'h40, 32'h4, 1, 1, 1, 4'h4, 32'h40, 1, 1);
    add(0, 0, 0, 1, 0, 0, 4'h0, 32'h0,  32'h0, 0, 1, 0, 4'h0, 32'h0,  0, 0);
    // backpressure: A, B, then C offered while full
    add(0, 0, 1, 0, 0, 1, 4'h5, 32'h50, 32'h5, 1, 1, 1, 4'h5, 32'h50, 1, 1);
    add(0, 0, 1, 0, 0, 1, 4'h6, 32'h60, 32'h6, 1, 0, 2, 4'h5, 32'h50, 1, 1);
    add(0, 0, 1, 0, 0, 1, 4'h7, 32'h70, 32'h7, 1, 0, 2, 4'h5, 32'h50, 1, 1);
    add(0, 0, 1, 0, 0, 1, 4'h7, 32'h70, 32'h7, 1, 0, 2, 4'h5, 32'h50, 1, 1);
    add(0, 0, 1, 0, 0, 1, 4'h7, 32'h70, 32'h7, 1, 0, 2, 4'h5, 32'h50, 1, 1);
    add(0, 0, 1, 1, 0, 1, 4'h7, 32'h70, 32'h7, 1, 1, 1, 4'h6, 32'h60, 1, 1);
    add(0, 0, 1, 1, 0, 1, 4'h7, 32'h70, 32'h7, 1, 1, 1, 4'h7, 32'h70, 1, 1);
    add(0, 0, 0, 1, 0, 0, 4'h0, 32'h0,  32'h0, 0, 1, 0, 4'h0, 32'h0,  0, 0);
    // load mux, then a bubble entry
    add(0, 0, 1, 0, 1, 1, 4'h8, 32'h100, 32'hDEAD_BEEF, 1, 1, 1, 4'h8, 32'hDEAD_BEEF, 1, 1);
    add(0, 0, 1, 1, 0, 0, 4'h9, 32'h90,  32'h9,         1, 1, 1, 4'h9, 32'h90,        0, 1);
    add(0, 0, 0, 1, 0, 0, 4'h0, 32'h0,   32'h0,         0, 1, 0, 4'h0, 32'h0,         0, 0);
    // flush while full, with an entry offered
    add(0, 0, 1, 0, 0, 1, 4'hA, 32'hA0, 32'hA, 1, 1, 1, 4'hA, 32'hA0, 1, 1);
    add(0, 0, 1, 0, 0, 1, 4'hB, 32'hB0, 32'hB, 1, 0, 2, 4'hA, 32'hA0, 1, 1);
    add(0, 1, 1, 0, 0, 1, 4'hC, 32'hC0, 32'hC, 0, 1, 0, 4'h0, 32'h0,  0, 0);
    add(0, 0, 0, 1, 0, 0, 4'h0, 32'h0,  32'h0, 0, 1, 0, 4'h0, 32'h0,  0, 0);
    // reset while full, then a lone entry
    add(0, 0, 1, 0, 0, 1, 4'hD, 32'hD0, 32'hD, 1, 1, 1, 4'hD, 32'hD0, 1, 1);
    add(0, 0, 1, 0, 1, 1, 4'hE, 32'hE0, 32'hE, 1, 0, 2, 4'hD, 32'hD0, 1, 1);
    add(1, 0, 1, 0, 0, 1, 4'hF, 32'hF0, 32'hF, 0, 1, 0, 4'h0, 32'h0,  0, 1);
    add(0, 0, 1, 1, 0, 1, 4'h7, 32'h77, 32'h7, 1, 1, 1, 4'h7, 32'h77, 1, 1);
    add(0, 0, 0, 1, 0, 0, 4'h0, 32'h0,  32'h0, 0, 1, 0, 4'h0, 32'h0,  0, 0);

    @(negedge clk);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].flush, vq[i].iv, vq[i].ordy, vq[i].mr, vq[i].we,
            vq[i].dst, vq[i].alu, vq[i].mem);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vq[i].e_ir));
      chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vq[i].e_occ));
      chk($sformatf("v%0d wb_en", i),     32'(wb_en),     32'(vq[i].e_wbe));
      if (vq[i].chk_pay) begin
        chk($sformatf("v%0d dest", i),     32'(dest), 32'(vq[i].e_dst));
        chk($sformatf("v%0d wb_value", i), wb_value,  vq[i].e_wbv);
      end
    end

    // random traffic against a queue model (capacity 2, FIFO order)
    drive(1, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic r, f, iv, ordy, acc, pp;
      ent_t e;
      chk("rnd out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("rnd in_ready",  32'(in_ready),  32'(mq.size() < 2));
      chk("rnd occupancy", 32'(occupancy), 32'(mq.size()));
      if (mq.size() > 0) begin
        chk("rnd dest",       32'(dest),     32'(mq[0].dst));
        chk("rnd alu_result", alu_result,    mq[0].alu);
        chk("rnd mem_result", mem_result,    mq[0].mem);
        chk("rnd mem_read",   32'(mem_read), 32'(mq[0].mr));
        chk("rnd wb_en",      32'(wb_en),    32'(mq[0].we));
        chk("rnd wb_value",   wb_value,      mq[0].mr ? mq[0].mem : mq[0].alu);
      end else begin
        chk("rnd wb_en idle", 32'(wb_en), 32'h0);
      end
      r    = ($urandom_range(99) < 2);
      f    = ($urandom_range(99) < 3);
      iv   = ($urandom_range(99) < 70);
      ordy = ($urandom_range(99) < 60);
      e.mr = 1'($urandom); e.we = 1'($urandom); e.dst = 4'($urandom);
      e.alu = $urandom; e.mem = $urandom;
      drive(r, f, iv, ordy, e.mr, e.we, e.dst, e.alu, e.mem);
      acc = iv && (mq.size() < 2);
      pp  = ordy && (mq.size() > 0);
      if (r || f) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (acc) mq.push_back(e);
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
